// File: rtl/sliding_window_scheduler_pkg.sv
// Shared types and constants for the sliding-window pattern scheduler.
// The detector state is the length of the pattern prefix matched so far.
package sliding_window_scheduler_pkg;

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4,
    S5 = 3'd5,
    S6 = 3'd6,
    S7 = 3'd7
  } det_state_e;

  localparam logic [7:0] PATTERN       = 8'b11100111;
  localparam int         CNT_W_DEFAULT = 8;

endpackage

// File: rtl/sliding_window_scheduler_detector_step.sv
// Combinational single-bit step of the 11100111 detector.
// One instance is shared by all channels; the caller muxes in the granted context.
module detector_step
  import sliding_window_scheduler_pkg::*;
(
  input  det_state_e state_i,
  input  logic       bit_i,
  output det_state_e next_state_o,
  output logic       dec_o
);

  always_comb begin
    next_state_o = S0;
    dec_o        = 1'b0;
    if (bit_i == PATTERN[3'd7 - state_i]) begin
      // Expected bit: extend the prefix; a full match falls back to the "111" overlap.
      if (state_i == S7) begin
        next_state_o = S3;
        dec_o        = 1'b1;
      end else begin
        next_state_o = det_state_e'(state_i + 3'd1);
      end
    end else begin
      // Mismatch: longest suffix of the seen bits that is still a pattern prefix.
      case (state_i)
        S3:      next_state_o = S3;
        S4:      next_state_o = S1;
        default: next_state_o = S0;
      endcase
    end
  end

endmodule

// File: rtl/sliding_window_scheduler.sv
// Round-robin sharing of one 11100111 detector among N_CH serial channels,
// with per-channel saved detector context and saturating match counters.
module sliding_window_scheduler
  import sliding_window_scheduler_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic [N_CH-1:0]         req,
  input  logic [N_CH-1:0]         bit_in,
  output logic [N_CH-1:0]         gnt,
  output logic                    dec_valid,
  output logic [$clog2(N_CH)-1:0] dec_ch,
  input  logic [$clog2(N_CH)-1:0] cnt_sel,
  output logic [CNT_W-1:0]        cnt_out,
  output logic [3*N_CH-1:0]       ctx_dbg
);

  localparam int IDX_W = $clog2(N_CH);

  // Handshake: bit_in[i] is consumed exactly in a cycle where req[i] & gnt[i];
  // otherwise the source must hold req[i]/bit_in[i] and nothing is taken.

  det_state_e       ctx_q [N_CH];
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             dec_valid_q;
  logic [IDX_W-1:0] dec_ch_q;

  logic             gnt_any;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W-1:0] scan_idx;
  det_state_e       step_next;
  logic             step_dec;

  always_comb begin
    gnt      = '0;
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    scan_idx = '0;
    if (rst_n && !clr) begin
      for (int k = 0; k < N_CH; k++) begin
        scan_idx = ptr_q + IDX_W'(k);
        if (!gnt_any && req[scan_idx]) begin
          gnt_any = 1'b1;
          gnt_idx = scan_idx;
        end
      end
    end
    gnt[gnt_idx] = gnt_any;
    ptr_d        = gnt_idx + IDX_W'(1);
  end

  detector_step u_step (
    .state_i      (ctx_q[gnt_idx]),
    .bit_i        (bit_in[gnt_idx]),
    .next_state_o (step_next),
    .dec_o        (step_dec)
  );

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      for (int i = 0; i < N_CH; i++) begin
        ctx_q[i] <= S0;
        cnt_q[i] <= '0;
      end
      ptr_q       <= '0;
      dec_valid_q <= 1'b0;
      dec_ch_q    <= '0;
    end else begin
      dec_valid_q <= gnt_any && step_dec;
      if (gnt_any) begin
        ctx_q[gnt_idx] <= step_next;
        ptr_q          <= ptr_d;
        if (step_dec) begin
          dec_ch_q <= gnt_idx;
          if (cnt_q[gnt_idx] != '1) begin
            cnt_q[gnt_idx] <= cnt_q[gnt_idx] + CNT_W'(1);
          end
        end
      end
    end
  end

  assign dec_valid = dec_valid_q;
  assign dec_ch    = dec_ch_q;
  assign cnt_out   = cnt_q[cnt_sel];

  for (genvar i = 0; i < N_CH; i++) begin : g_dbg
    assign ctx_dbg[3*i +: 3] = ctx_q[i];
  end

endmodule

// File: tb/tb_sliding_window_scheduler.sv
// Bench for sliding_window_scheduler: per-channel bit streams, a window-based
// reference model, and a cycle-tagged expected-match queue drained by a monitor.
module tb_sliding_window_scheduler;
  import sliding_window_scheduler_pkg::*;

  localparam int N    = 4;
  localparam int CW   = 8;
  localparam int IW   = 2;
  localparam int EW   = 16 + IW;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic          clr;
  logic [N-1:0]  req;
  logic [N-1:0]  bit_in;
  logic [N-1:0]  gnt;
  logic          dec_valid;
  logic [IW-1:0] dec_ch;
  logic [IW-1:0] cnt_sel;
  logic [CW-1:0] cnt_out;
  logic [3*N-1:0] ctx_dbg;

  sliding_window_scheduler #(.N_CH(N), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .req       (req),
    .bit_in    (bit_in),
    .gnt       (gnt),
    .dec_valid (dec_valid),
    .dec_ch    (dec_ch),
    .cnt_sel   (cnt_sel),
    .cnt_out   (cnt_out),
    .ctx_dbg   (ctx_dbg)
  );

  // ---------------- clock / cycle counter ----------------
  initial clk = 1'b0;
  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: time limit reached, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];   // {due_cycle[15:0], channel}
  logic stream_q[N][$];
  int  hist[N];
  int  nbits[N];
  int  mcnt[N];
  int  ptr_m;
  int  gcount[N];
  bit  all_req = 0;
  bit  drop_en = 0;
  bit  done    = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      hist[i]  = 0;
      nbits[i] = 0;
      mcnt[i]  = 0;
    end
    ptr_m = 0;
  endtask

  // Longest suffix of the bits seen since the last clear that is a proper pattern prefix.
  function automatic int model_ctx(input int ch);
    for (int len = 7; len >= 0; len--) begin
      if (nbits[ch] >= len &&
          (hist[ch] & ((1 << len) - 1)) == (int'(PATTERN) >> (8 - len)))
        return len;
    end
    return 0;
  endfunction

  function automatic bit streams_busy();
    for (int i = 0; i < N; i++)
      if (stream_q[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push_bits(input int ch, input int n, input logic [31:0] v);
    for (int i = n - 1; i >= 0; i--) stream_q[ch].push_back(v[i]);
  endtask

  // One cycle: drive at negedge, check grant, advance the model, wait next negedge.
  task automatic step_cycle(input bit c);
    logic [N-1:0] r;
    logic [N-1:0] b;
    int g;
    int idx;
    r = '0;
    b = '0;
    for (int i = 0; i < N; i++) begin
      b[i] = 1'($urandom_range(0, 1));
      if (all_req) begin
        r[i] = 1'b1;
      end else if (stream_q[i].size() > 0 && (!drop_en || $urandom_range(0, 3) != 0)) begin
        r[i] = 1'b1;
        b[i] = stream_q[i][0];
      end
    end
    req    = r;
    bit_in = b;
    clr    = c;
    #1;
    g = -1;
    if (!c) begin
      for (int k = 0; k < N; k++) begin
        idx = (ptr_m + k) % N;
        if (g < 0 && r[idx]) g = idx;
      end
    end
    check("gnt", int'(gnt), (g < 0) ? 0 : (1 << g));
    for (int i = 0; i < N; i++) if (gnt[i]) gcount[i]++;
    if (c) begin
      model_clear();
    end else if (g >= 0) begin
      hist[g]  = ((hist[g] << 1) | int'(b[g])) & 8'hFF;
      nbits[g] = nbits[g] + 1;
      ptr_m    = (g + 1) % N;
      if (!all_req) void'(stream_q[g].pop_front());
      if (nbits[g] >= 8 && hist[g] == int'(PATTERN)) begin
        exp_q.push_back({16'(cyc + 1), IW'(g)});
        if (mcnt[g] < CMAX) mcnt[g]++;
      end
    end
    @(negedge clk);
  endtask

  task automatic run_streams(input int budget);
    int n;
    n = 0;
    while (streams_busy() && n < budget) begin
      step_cycle(drop_en && $urandom_range(0, 49) == 0);
      n++;
    end
    checks++;
    if (streams_busy()) begin
      errors++;
      $display("FAIL stream_timeout: streams still pending after %0d cycles, required empty", budget);
      for (int i = 0; i < N; i++) stream_q[i].delete();
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step_cycle(1'b0);
  endtask

  task automatic check_all();
    for (int i = 0; i < N; i++) begin
      cnt_sel = IW'(i);
      #1;
      check($sformatf("cnt_out[%0d]", i), int'(cnt_out), mcnt[i]);
      check($sformatf("ctx[%0d]", i), int'(ctx_dbg[3*i +: 3]), model_ctx(i));
    end
  endtask

  task automatic check_cnt_const(input int ch, input int val, input string name);
    cnt_sel = IW'(ch);
    #1;
    check(name, int'(cnt_out), val);
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [EW-1:0] e;
    forever begin
      @(posedge clk);
      #2;
      if (done) break;
      if (dec_valid) begin
        checks++;
        if (exp_q.size() == 0 || exp_q[0][EW-1:IW] != 16'(cyc)) begin
          errors++;
          $display("FAIL dec_unexpected: dec_valid=1 dec_ch=%0d at cycle %0d, required no match", dec_ch, cyc);
        end else begin
          e = exp_q.pop_front();
          if (dec_ch !== e[IW-1:0]) begin
            errors++;
            $display("FAIL dec_ch: got %0d, expected %0d (cycle %0d)", dec_ch, e[IW-1:0], cyc);
          end
        end
      end else if (exp_q.size() > 0 && exp_q[0][EW-1:IW] <= 16'(cyc)) begin
        e = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL dec_missing: dec_valid=0 at cycle %0d, expected match on ch %0d", cyc, e[IW-1:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n   = 1'b0;
    clr     = 1'b0;
    req     = '1;
    bit_in  = '1;
    cnt_sel = '0;
    model_clear();
    for (int i = 0; i < N; i++) gcount[i] = 0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_gnt", int'(gnt), 0);
    check("reset_dec_valid", int'(dec_valid), 0);
    check("reset_dec_ch", int'(dec_ch), 0);
    check("reset_cnt_out", int'(cnt_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    req   = '0;

    // Single channel, one full pattern
    push_bits(0, 8, 32'(PATTERN));
    run_streams(50);
    idle(2);
    check_all();
    check_cnt_const(0, 1, "single_cnt0");

    // Overlapping matches on ch1
    push_bits(1, 13, 32'b1110011100111);
    run_streams(50);
    idle(2);
    check_all();
    check_cnt_const(1, 2, "overlap_cnt1");
    check("overlap_ctx1", int'(ctx_dbg[5:3]), 3);

    // Interleaving with context isolation
    step_cycle(1'b1);
    push_bits(0, 8, 32'(PATTERN));
    push_bits(2, 8, 32'b11100110);
    run_streams(50);
    idle(2);
    check_all();
    check_cnt_const(0, 1, "interleave_cnt0");
    check_cnt_const(2, 0, "interleave_cnt2");

    // Fairness with all requests held
    step_cycle(1'b1);
    for (int i = 0; i < N; i++) gcount[i] = 0;
    all_req = 1;
    repeat (16) step_cycle(1'b0);
    all_req = 0;
    for (int i = 0; i < N; i++) check($sformatf("fair_grants[%0d]", i), gcount[i], 4);
    idle(2);
    check_all();

    // Saturation: 256 matches on ch3
    step_cycle(1'b1);
    push_bits(3, 8, 32'(PATTERN));
    for (int m = 1; m < 256; m++) push_bits(3, 5, 32'b00111);
    run_streams(2000);
    idle(2);
    check_all();
    check_cnt_const(3, 255, "sat_cnt3");

    // clr mid-pattern
    step_cycle(1'b1);
    push_bits(0, 7, 32'b1110011);
    run_streams(50);
    push_bits(0, 1, 32'b1);
    step_cycle(1'b1);
    run_streams(50);
    idle(2);
    check_all();
    check("clr_ctx0", int'(ctx_dbg[2:0]), 1);
    check_cnt_const(3, 0, "clr_cnt3");

    // Randomized traffic with dropped requests and occasional clears
    drop_en = 1;
    repeat (6) begin
      for (int ch = 0; ch < N; ch++) begin
        repeat ($urandom_range(2, 6)) begin
          if ($urandom_range(0, 1) == 1) push_bits(ch, 8, 32'(PATTERN));
          else push_bits(ch, 5, 32'($urandom_range(0, 31)));
        end
      end
      run_streams(2000);
      idle(2);
      check_all();
    end
    drop_en = 0;

    idle(3);
    check("exp_q_drained", exp_q.size(), 0);
    done = 1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
